// File: rtl/date_setter_if.sv
// Bundle between the button debouncers / calendar counters and the date_setter
// edit controller. The slave modport is the date_setter side.
interface date_setter_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] cur_dt;
  logic [3:0] cur_du;
  logic [3:0] cur_mt;
  logic [3:0] cur_mu;
  logic       editing;
  logic [1:0] sel;
  logic [3:0] edit_dt;
  logic [3:0] edit_du;
  logic [3:0] edit_mt;
  logic [3:0] edit_mu;
  logic       load_en;
  logic [4:0] load_day;
  logic [3:0] load_month;

  modport master (
    output btn_mode, btn_up, btn_down, cur_dt, cur_du, cur_mt, cur_mu,
    input  editing, sel, edit_dt, edit_du, edit_mt, edit_mu,
           load_en, load_day, load_month
  );

  modport slave (
    input  btn_mode, btn_up, btn_down, cur_dt, cur_du, cur_mt, cur_mu,
    output editing, sel, edit_dt, edit_du, edit_mt, edit_mu,
           load_en, load_day, load_month
  );
endinterface

// File: rtl/date_setter.sv
// Date-edit controller: captures the BCD date, steps month then day, commits with
// a one-cycle load strobe. Optional edit abort timer: DATE_SETTER_TIMEOUT_EN.
module date_setter #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  date_setter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EDIT_MONTH = 2'd1,
    EDIT_DAY   = 2'd2,
    COMMIT     = 2'd3
  } state_t;

  function automatic logic [4:0] month_max(input logic [3:0] m);
    case (m)
      4'd2:                        month_max = 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:     month_max = 5'd30;
      default:                     month_max = 5'd31;
    endcase
  endfunction

  // Values are at most 31, so tens is found by comparison instead of a divider.
  function automatic logic [7:0] to_bcd(input logic [4:0] v);
    if (v >= 5'd30) begin
      to_bcd = {4'd3, 4'(v - 5'd30)};
    end else if (v >= 5'd20) begin
      to_bcd = {4'd2, 4'(v - 5'd20)};
    end else if (v >= 5'd10) begin
      to_bcd = {4'd1, 4'(v - 5'd10)};
    end else begin
      to_bcd = {4'd0, v[3:0]};
    end
  endfunction

  if (TIMEOUT_CYCLES < 32'd1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be non-zero");
  end

  state_t      state_r, state_s;
  logic [4:0]  d_r, d_s;
  logic [3:0]  m_r, m_s;
  logic [4:0]  load_day_r;
  logic [3:0]  load_month_r;
  logic [7:0]  cap_m_s, cap_d_s;
  logic [3:0]  cap_month_s;
  logic [4:0]  cap_max_s, cap_day_s, max_r_s, new_max_s;
  logic        step_up_s, step_dn_s, any_btn_s, in_edit_s, timeout_s;
  logic [7:0]  day_bcd_s, month_bcd_s;
  logic [1:0]  sel_s;

  assign cap_m_s   = ({4'd0, bus.cur_mt} * 8'd10) + {4'd0, bus.cur_mu};
  assign cap_d_s   = ({4'd0, bus.cur_dt} * 8'd10) + {4'd0, bus.cur_du};
  assign step_up_s = bus.btn_up & ~bus.btn_down & ~bus.btn_mode;
  assign step_dn_s = bus.btn_down & ~bus.btn_up & ~bus.btn_mode;
  assign any_btn_s = bus.btn_mode | bus.btn_up | bus.btn_down;
  assign in_edit_s = (state_r == EDIT_MONTH) || (state_r == EDIT_DAY);
  assign max_r_s   = month_max(m_r);

  // Legalise the captured date: bad month becomes January, day clamped to 1..max.
  always_comb begin
    cap_month_s = 4'd1;
    cap_day_s   = 5'd1;
    if ((cap_m_s == 8'd0) || (cap_m_s > 8'd12)) begin
      cap_month_s = 4'd1;
    end else begin
      cap_month_s = cap_m_s[3:0];
    end
    cap_max_s = month_max(cap_month_s);
    if (cap_d_s == 8'd0) begin
      cap_day_s = 5'd1;
    end else if (cap_d_s > {3'd0, cap_max_s}) begin
      cap_day_s = cap_max_s;
    end else begin
      cap_day_s = cap_d_s[4:0];
    end
  end

`ifdef DATE_SETTER_TIMEOUT_EN
  logic [31:0] cnt_r, cnt_s;

  assign timeout_s = in_edit_s && !any_btn_s && (cnt_r == (TIMEOUT_CYCLES - 32'd1));

  // Idle counter restarts on state entry and on every button pulse.
  always_comb begin
    cnt_s = 32'd0;
    if (in_edit_s && (state_s == state_r) && !any_btn_s) begin
      cnt_s = cnt_r + 32'd1;
    end else begin
      cnt_s = 32'd0;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 32'd0;
    end else begin
      cnt_r <= cnt_s;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next state and working-register update; btn_mode outranks the step buttons.
  always_comb begin
    state_s   = state_r;
    d_s       = d_r;
    m_s       = m_r;
    new_max_s = max_r_s;
    case (state_r)
      IDLE: begin
        if (bus.btn_mode) begin
          state_s = EDIT_MONTH;
          m_s     = cap_month_s;
          d_s     = cap_day_s;
        end else begin
          state_s = IDLE;
        end
      end
      EDIT_MONTH: begin
        if (bus.btn_mode) begin
          state_s = EDIT_DAY;
        end else if (timeout_s) begin
          state_s = IDLE;
        end else if (step_up_s || step_dn_s) begin
          if (step_up_s) begin
            m_s = (m_r == 4'd12) ? 4'd1 : (m_r + 4'd1);
          end else begin
            m_s = (m_r == 4'd1) ? 4'd12 : (m_r - 4'd1);
          end
          new_max_s = month_max(m_s);
          d_s       = (d_r > new_max_s) ? new_max_s : d_r;
        end else begin
          state_s = EDIT_MONTH;
        end
      end
      EDIT_DAY: begin
        if (bus.btn_mode) begin
          state_s = COMMIT;
        end else if (timeout_s) begin
          state_s = IDLE;
        end else if (step_up_s) begin
          d_s = (d_r == max_r_s) ? 5'd1 : (d_r + 5'd1);
        end else if (step_dn_s) begin
          d_s = (d_r == 5'd1) ? max_r_s : (d_r - 5'd1);
        end else begin
          state_s = EDIT_DAY;
        end
      end
      COMMIT: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      d_r     <= 5'd1;
      m_r     <= 4'd1;
    end else begin
      state_r <= state_s;
      d_r     <= d_s;
      m_r     <= m_s;
    end
  end

  // Commit values are latched on the edge that enters COMMIT and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_day_r   <= 5'd1;
      load_month_r <= 4'd1;
    end else if ((state_r == EDIT_DAY) && bus.btn_mode) begin
      load_day_r   <= d_r;
      load_month_r <= m_r;
    end else begin
      load_day_r   <= load_day_r;
      load_month_r <= load_month_r;
    end
  end

  // Field-select code for the display blink.
  always_comb begin
    sel_s = 2'b00;
    case (state_r)
      EDIT_MONTH: sel_s = 2'b01;
      EDIT_DAY:   sel_s = 2'b10;
      default:    sel_s = 2'b00;
    endcase
  end

  assign day_bcd_s   = to_bcd(d_r);
  assign month_bcd_s = to_bcd({1'b0, m_r});

  assign bus.editing    = in_edit_s;
  assign bus.sel        = sel_s;
  assign bus.edit_dt    = day_bcd_s[7:4];
  assign bus.edit_du    = day_bcd_s[3:0];
  assign bus.edit_mt    = month_bcd_s[7:4];
  assign bus.edit_mu    = month_bcd_s[3:0];
  assign bus.load_en    = (state_r == COMMIT);
  assign bus.load_day   = load_day_r;
  assign bus.load_month = load_month_r;

endmodule

// File: tb/tb_date_setter.sv
// Directed self-checking bench for date_setter; timeout scenario is built
// only when DATE_SETTER_TIMEOUT_EN is defined (TIMEOUT_CYCLES forced to 16).
module tb_date_setter;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  date_setter_if bus ();

  date_setter #(.TIMEOUT_CYCLES(32'd16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {editing, sel, edit_dt, edit_du, edit_mt, edit_mu}
  function automatic logic [18:0] view();
    return {bus.editing, bus.sel, bus.edit_dt, bus.edit_du, bus.edit_mt, bus.edit_mu};
  endfunction

  // {load_en, load_day, load_month}
  function automatic logic [9:0] lview();
    return {bus.load_en, bus.load_day, bus.load_month};
  endfunction

  task automatic press(input logic m, input logic u, input logic d);
    @(negedge clk);
    bus.btn_mode = m;
    bus.btn_up   = u;
    bus.btn_down = d;
    @(negedge clk);
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
  endtask

  task automatic set_cur(input logic [3:0] dt, input logic [3:0] du,
                         input logic [3:0] mt, input logic [3:0] mu);
    bus.cur_dt = dt;
    bus.cur_du = du;
    bus.cur_mt = mt;
    bus.cur_mu = mu;
  endtask

  task automatic leave_edit();
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (view() !== {1'b0, 2'b00, 4'd0, 4'd1, 4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL reset_view: got=%h exp=%h", view(), {1'b0, 2'b00, 4'd0, 4'd1, 4'd0, 4'd1});
    end
    n_tests++;
    if (lview() !== {1'b0, 5'd1, 4'd1}) begin
      n_fail++;
      $display("FAIL reset_load: got=%h exp=%h", lview(), {1'b0, 5'd1, 4'd1});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_edit();
    set_cur(4'd1, 4'd2, 4'd1, 4'd2);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (view() !== {1'b1, 2'b10, 4'd1, 4'd2, 4'd1, 4'd2}) begin
      n_fail++;
      $display("FAIL pre_reset_edit_day: got=%h exp=%h", view(), {1'b1, 2'b10, 4'd1, 4'd2, 4'd1, 4'd2});
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (view() !== {1'b0, 2'b00, 4'd0, 4'd1, 4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL mid_edit_reset_view: got=%h exp=%h", view(), {1'b0, 2'b00, 4'd0, 4'd1, 4'd0, 4'd1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (lview() !== {1'b0, 5'd1, 4'd1}) begin
      n_fail++;
      $display("FAIL mid_edit_reset_load: got=%h exp=%h", lview(), {1'b0, 5'd1, 4'd1});
    end
  endtask

  task automatic test_capture();
    set_cur(4'd3, 4'd1, 4'd0, 4'd1);
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (view() !== {1'b1, 2'b01, 4'd3, 4'd1, 4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL capture_31jan: got=%h exp=%h", view(), {1'b1, 2'b01, 4'd3, 4'd1, 4'd0, 4'd1});
    end
    press(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (view() !== {1'b1, 2'b01, 4'd2, 4'd8, 4'd0, 4'd2}) begin
      n_fail++;
      $display("FAIL feb_clamp_28: got=%h exp=%h", view(), {1'b1, 2'b01, 4'd2, 4'd8, 4'd0, 4'd2});
    end
  endtask

  task automatic test_month_wrap();
    press(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (view() !== {1'b1, 2'b01, 4'd2, 4'd8, 4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL month_2_down: got=%h exp=%h", view(), {1'b1, 2'b01, 4'd2, 4'd8, 4'd0, 4'd1});
    end
    press(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (view() !== {1'b1, 2'b01, 4'd2, 4'd8, 4'd1, 4'd2}) begin
      n_fail++;
      $display("FAIL month_1_down_wrap: got=%h exp=%h", view(), {1'b1, 2'b01, 4'd2, 4'd8, 4'd1, 4'd2});
    end
    press(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (view() !== {1'b1, 2'b01, 4'd2, 4'd8, 4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL month_12_up_wrap: got=%h exp=%h", view(), {1'b1, 2'b01, 4'd2, 4'd8, 4'd0, 4'd1});
    end
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (view() !== {1'b1, 2'b10, 4'd2, 4'd8, 4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL enter_edit_day: got=%h exp=%h", view(), {1'b1, 2'b10, 4'd2, 4'd8, 4'd0, 4'd1});
    end
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (lview() !== {1'b1, 5'd28, 4'd1}) begin
      n_fail++;
      $display("FAIL commit_28jan: got=%h exp=%h", lview(), {1'b1, 5'd28, 4'd1});
    end
    @(negedge clk);
  endtask

  task automatic test_day_wrap();
    set_cur(4'd3, 4'd0, 4'd0, 4'd4);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (view() !== {1'b1, 2'b10, 4'd3, 4'd0, 4'd0, 4'd4}) begin
      n_fail++;
      $display("FAIL day_30apr: got=%h exp=%h", view(), {1'b1, 2'b10, 4'd3, 4'd0, 4'd0, 4'd4});
    end
    press(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (view() !== {1'b1, 2'b10, 4'd0, 4'd1, 4'd0, 4'd4}) begin
      n_fail++;
      $display("FAIL day_30_up_wrap: got=%h exp=%h", view(), {1'b1, 2'b10, 4'd0, 4'd1, 4'd0, 4'd4});
    end
    press(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (view() !== {1'b1, 2'b10, 4'd3, 4'd0, 4'd0, 4'd4}) begin
      n_fail++;
      $display("FAIL day_1_down_wrap: got=%h exp=%h", view(), {1'b1, 2'b10, 4'd3, 4'd0, 4'd0, 4'd4});
    end
    press(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (view() !== {1'b1, 2'b10, 4'd2, 4'd9, 4'd0, 4'd4}) begin
      n_fail++;
      $display("FAIL day_30_down: got=%h exp=%h", view(), {1'b1, 2'b10, 4'd2, 4'd9, 4'd0, 4'd4});
    end
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (lview() !== {1'b1, 5'd29, 4'd4}) begin
      n_fail++;
      $display("FAIL commit_29apr: got=%h exp=%h", lview(), {1'b1, 5'd29, 4'd4});
    end
    @(negedge clk);
  endtask

  task automatic test_commit();
    set_cur(4'd1, 4'd4, 4'd0, 4'd3);
    press(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) press(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (view() !== {1'b1, 2'b01, 4'd1, 4'd4, 4'd1, 4'd1}) begin
      n_fail++;
      $display("FAIL month_to_nov: got=%h exp=%h", view(), {1'b1, 2'b01, 4'd1, 4'd4, 4'd1, 4'd1});
    end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (view() !== {1'b1, 2'b10, 4'd1, 4'd5, 4'd1, 4'd1}) begin
      n_fail++;
      $display("FAIL day_to_15: got=%h exp=%h", view(), {1'b1, 2'b10, 4'd1, 4'd5, 4'd1, 4'd1});
    end
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if ({lview(), bus.editing} !== {1'b1, 5'd15, 4'd11, 1'b0}) begin
      n_fail++;
      $display("FAIL commit_15nov: got=%h exp=%h", {lview(), bus.editing}, {1'b1, 5'd15, 4'd11, 1'b0});
    end
    @(negedge clk);
    n_tests++;
    if ({lview(), bus.editing, bus.sel} !== {1'b0, 5'd15, 4'd11, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL after_commit_hold: got=%h exp=%h", {lview(), bus.editing, bus.sel}, {1'b0, 5'd15, 4'd11, 1'b0, 2'b00});
    end
    press(1'b0, 1'b1, 1'b0);
    n_tests++;
    if ({view(), lview()} !== {1'b0, 2'b00, 4'd1, 4'd5, 4'd1, 4'd1, 1'b0, 5'd15, 4'd11}) begin
      n_fail++;
      $display("FAIL idle_ignores_up: got=%h exp=%h", {view(), lview()}, {1'b0, 2'b00, 4'd1, 4'd5, 4'd1, 4'd1, 1'b0, 5'd15, 4'd11});
    end
  endtask

  task automatic test_simultaneous();
    set_cur(4'd1, 4'd0, 4'd0, 4'd6);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b1);
    n_tests++;
    if (view() !== {1'b1, 2'b01, 4'd1, 4'd0, 4'd0, 4'd6}) begin
      n_fail++;
      $display("FAIL month_up_down_same: got=%h exp=%h", view(), {1'b1, 2'b01, 4'd1, 4'd0, 4'd0, 4'd6});
    end
    press(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (view() !== {1'b1, 2'b10, 4'd1, 4'd0, 4'd0, 4'd6}) begin
      n_fail++;
      $display("FAIL mode_beats_up: got=%h exp=%h", view(), {1'b1, 2'b10, 4'd1, 4'd0, 4'd0, 4'd6});
    end
    press(1'b0, 1'b1, 1'b1);
    n_tests++;
    if (view() !== {1'b1, 2'b10, 4'd1, 4'd0, 4'd0, 4'd6}) begin
      n_fail++;
      $display("FAIL day_up_down_same: got=%h exp=%h", view(), {1'b1, 2'b10, 4'd1, 4'd0, 4'd0, 4'd6});
    end
    press(1'b1, 1'b0, 1'b1);
    n_tests++;
    if (lview() !== {1'b1, 5'd10, 4'd6}) begin
      n_fail++;
      $display("FAIL mode_beats_down_commit: got=%h exp=%h", lview(), {1'b1, 5'd10, 4'd6});
    end
    @(negedge clk);
  endtask

  task automatic test_capture_clamp();
    logic [15:0] cur_tab [4];
    logic [15:0] exp_tab [4];
    logic [15:0] cv;
    cur_tab = '{16'h3104, 16'h3113, 16'h0000, 16'h3102};
    exp_tab = '{16'h3004, 16'h3101, 16'h0101, 16'h2802};
    for (int i = 0; i < 4; i++) begin
      cv = cur_tab[i];
      set_cur(cv[15:12], cv[11:8], cv[7:4], cv[3:0]);
      press(1'b1, 1'b0, 1'b0);
      n_tests++;
      if (view() !== {1'b1, 2'b01, exp_tab[i]}) begin
        n_fail++;
        $display("FAIL capture_clamp_%0d: got=%h exp=%h", i, view(), {1'b1, 2'b01, exp_tab[i]});
      end
      leave_edit();
    end
  endtask

  task automatic test_timeout();
    logic seen_load;
    set_cur(4'd0, 4'd9, 4'd0, 4'd5);
`ifdef DATE_SETTER_TIMEOUT_EN
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    seen_load = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      seen_load = seen_load | bus.load_en;
    end
    n_tests++;
    if (bus.editing !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: got=%b exp=%b", bus.editing, 1'b1);
    end
    @(negedge clk);
    seen_load = seen_load | bus.load_en;
    n_tests++;
    if ({bus.editing, seen_load} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_abort: got=%b exp=%b", {bus.editing, seen_load}, 2'b00);
    end
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    press(1'b0, 1'b1, 1'b0);
    repeat (15) @(negedge clk);
    n_tests++;
    if (bus.editing !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_restart_hold: got=%b exp=%b", bus.editing, 1'b1);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.editing, bus.load_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_restart_abort: got=%b exp=%b", {bus.editing, bus.load_en}, 2'b00);
    end
`else
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    seen_load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen_load = seen_load | bus.load_en;
    end
    n_tests++;
    if ({bus.editing, bus.sel, seen_load} !== {1'b1, 2'b10, 1'b0}) begin
      n_fail++;
      $display("FAIL edit_persists: got=%b exp=%b", {bus.editing, bus.sel, seen_load}, {1'b1, 2'b10, 1'b0});
    end
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (lview() !== {1'b1, 5'd9, 4'd5}) begin
      n_fail++;
      $display("FAIL persist_commit: got=%h exp=%h", lview(), {1'b1, 5'd9, 4'd5});
    end
    @(negedge clk);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    set_cur(4'd0, 4'd1, 4'd0, 4'd1);
    test_reset();
    test_reset_mid_edit();
    test_capture();
    test_month_wrap();
    test_day_wrap();
    test_commit();
    test_simultaneous();
    test_capture_clamp();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
